ws2812_rx: RTL and testbench



---
 rtl/ws2812_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 single-wire receiver: pulse-width bit decode, GRB pixel assembly, latch detect
//
// Purpose: decodes the WS2812 serial stream produced by a ws2812c-style driver
// back into 24-bit GRB pixels tagged with their position in the frame.
//
// Ports:
//   clk         - system clock
//   reset       - synchronous, active-low reset
//   DI          - asynchronous serial WS2812 data in
//   address     - pixel index for the current pixel_valid pixel
//   red/green/blue - decoded colour bytes, held until the next pixel_valid
//   pixel_valid - one-cycle strobe, new pixel on address/red/green/blue
//   frame_done  - one-cycle strobe when the latch gap is detected
//   error       - one-cycle strobe on a protocol violation
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 48_000_000,
  parameter int THRESH_NS    = 600,
  parameter int MIN_HIGH_NS  = 100,
  parameter int LATCH_NS     = 50_000,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          DI,
  output logic [AW-1:0] address,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          pixel_valid,
  output logic          frame_done,
  output logic          error
);

  localparam int CPM        = SYSTEM_CLOCK / 1_000_000;
  localparam int THRESH_CYC = CPM * THRESH_NS / 1000;
  localparam int MIN_CYC    = CPM * MIN_HIGH_NS / 1000;
  localparam int LATCH_CYC  = CPM * LATCH_NS / 1000;
  localparam int CW         = $clog2(LATCH_CYC + 1);
  // Pointer counts up to NUM_LEDS inclusive so overflow pixels are recognisable.
  localparam int PW         = $clog2(NUM_LEDS + 1);

  localparam logic [CW-1:0] LATCH_C  = CW'(LATCH_CYC);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH_CYC);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_CYC);
  localparam logic [PW-1:0] NUM_P    = PW'(NUM_LEDS);

  typedef enum logic [1:0] {S_SYNC = 2'd0, S_READY = 2'd1, S_HIGH = 2'd2} state_t;

  state_t         state_q, state_d;
  logic           sync1_q, din_s_q;
  logic [CW-1:0]  lcnt_q, lcnt_d;
  logic [CW-1:0]  hcnt_q, hcnt_d;
  logic [4:0]     bitcnt_q, bitcnt_d;
  logic [23:0]    shift_q, shift_d;
  logic           pend_q, pend_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           ovf_q, ovf_d;
  logic [AW-1:0]  address_q, address_d;
  logic [7:0]     red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic           pixel_valid_q, pixel_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           error_q, error_d;

  logic [CW-1:0]  lcnt_inc, hcnt_inc;
  logic           lcnt_sat, latch_hit, sync_done, hi_stuck, hi_glitch, bit_accept;

  assign lcnt_inc   = lcnt_q + 1'b1;
  assign hcnt_inc   = hcnt_q + 1'b1;
  assign lcnt_sat   = (lcnt_q == LATCH_C);
  // A saturated low counter means this gap was already reported (or came from
  // SYNC), so only the transition into LATCH_CYC ends a frame.
  assign latch_hit  = (state_q == S_READY) && !din_s_q && !lcnt_sat && (lcnt_inc == LATCH_C);
  assign sync_done  = (state_q == S_SYNC) && !din_s_q && (lcnt_inc == LATCH_C);
  assign hi_stuck   = (state_q == S_HIGH) && din_s_q && (hcnt_inc == LATCH_C);
  assign hi_glitch  = (state_q == S_HIGH) && !din_s_q && (hcnt_q < MIN_C);
  assign bit_accept = (state_q == S_HIGH) && !din_s_q && !hi_glitch;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_SYNC;
      sync1_q       <= 1'b0;
      din_s_q       <= 1'b0;
      lcnt_q        <= '0;
      hcnt_q        <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      pend_q        <= 1'b0;
      ptr_q         <= '0;
      ovf_q         <= 1'b0;
      address_q     <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= DI;
      din_s_q       <= sync1_q;
      lcnt_q        <= lcnt_d;
      hcnt_q        <= hcnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      pend_q        <= pend_d;
      ptr_q         <= ptr_d;
      ovf_q         <= ovf_d;
      address_q     <= address_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:  if (sync_done) state_d = S_READY;
      S_READY: if (din_s_q) state_d = S_HIGH;
      S_HIGH: begin
        if (hi_stuck || hi_glitch) state_d = S_SYNC;
        else if (bit_accept)       state_d = S_READY;
      end
      default: state_d = S_SYNC;
    endcase
  end

  // Counters, shift register and output strobes
  always_comb begin
    lcnt_d        = lcnt_q;
    hcnt_d        = hcnt_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    pend_d        = 1'b0;
    ptr_d         = ptr_q;
    ovf_d         = ovf_q;
    address_d     = address_q;
    red_d         = red_q;
    green_d       = green_q;
    blue_d        = blue_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    error_d       = 1'b0;

    case (state_q)
      S_SYNC: lcnt_d = din_s_q ? '0 : lcnt_inc;
      S_READY: begin
        if (din_s_q) begin
          hcnt_d = CW'(1);
        end else if (!lcnt_sat) begin
          lcnt_d = lcnt_inc;
        end
        if (latch_hit) begin
          frame_done_d = 1'b1;
          ptr_d        = '0;
          ovf_d        = 1'b0;
          // A partial pixel at the latch is a truncated frame.
          error_d      = (bitcnt_q != 5'd0);
          bitcnt_d     = '0;
        end
      end
      S_HIGH: begin
        if (din_s_q) begin
          hcnt_d = lcnt_sat_h(hcnt_q) ? hcnt_q : hcnt_inc;
          if (hi_stuck) begin
            error_d  = 1'b1;
            bitcnt_d = '0;
            lcnt_d   = '0;
          end
        end else if (hi_glitch) begin
          error_d  = 1'b1;
          bitcnt_d = '0;
          lcnt_d   = CW'(1);
        end else begin
          shift_d = {shift_q[22:0], (hcnt_q >= THRESH_C)};
          lcnt_d  = CW'(1);
          if (bitcnt_q == 5'd23) begin
            bitcnt_d = '0;
            pend_d   = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end
      end
      default: ;
    endcase

    // Publish the assembled pixel one cycle after its last bit is accepted.
    if (pend_q) begin
      if (ptr_q < NUM_P) begin
        address_d     = ptr_q[AW-1:0];
        green_d       = shift_q[23:16];
        red_d         = shift_q[15:8];
        blue_d        = shift_q[7:0];
        pixel_valid_d = 1'b1;
        ptr_d         = ptr_q + 1'b1;
      end else if (!ovf_q) begin
        error_d = 1'b1;
        ovf_d   = 1'b1;
      end
    end
  end

  function automatic logic lcnt_sat_h(input logic [CW-1:0] v);
    return (v == LATCH_C);
  endfunction

  assign address     = address_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_done  = frame_done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - self-checking bench for ws2812_rx
module tb_ws2812_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       DI = 1'b0;
  logic [2:0] address;
  logic [7:0] red, green, blue;
  logic       pixel_valid, frame_done, error;

  ws2812_rx dut (
    .clk(clk), .reset(reset), .DI(DI), .address(address),
    .red(red), .green(green), .blue(blue),
    .pixel_valid(pixel_valid), .frame_done(frame_done), .error(error)
  );

  always #10 clk = ~clk;

  localparam int LATCH = 2400;
  localparam int GAP   = 2420;

  typedef struct {
    logic [23:0] grb;
    int          hi0;
    int          hi1;
    logic        exp_v;
    logic [2:0]  exp_a;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [23:0] grb;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  int total = 0, bad = 0;
  int pv_cnt = 0, fd_cnt = 0, err_cnt = 0, both_cnt = 0, pe_cnt = 0;
  int pv0, fd0, err0, both0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are observed at the falling edge, once per cycle.
  task automatic sample();
    exp_t e;
    if (pixel_valid) begin
      pv_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_pixel_valid", {29'd0, address}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("pixel", {5'd0, address, green, red, blue}, {5'd0, e.addr, e.grb});
      end
    end
    if (frame_done) fd_cnt++;
    if (error) err_cnt++;
    if (frame_done && error) both_cnt++;
    if (pixel_valid && error) pe_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int hi, input int lo);
    DI = 1'b1;
    repeat (hi) tick();
    DI = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic send_px(input logic [23:0] grb, input int hi0, input int hi1);
    for (int b = 23; b >= 0; b--) begin
      if (grb[b]) send_bit(hi1, 60 - hi1);
      else        send_bit(hi0, 60 - hi0);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [23:0] grb);
    exp_t e;
    e.addr = a;
    e.grb  = grb;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int i);
    if (vecs[i].exp_v) push(vecs[i].exp_a, vecs[i].grb);
    send_px(vecs[i].grb, vecs[i].hi0, vecs[i].hi1);
  endtask

  task automatic latch();
    DI = 1'b0;
    repeat (GAP) tick();
  endtask

  task automatic snap();
    pv0 = pv_cnt; fd0 = fd_cnt; err0 = err_cnt; both0 = both_cnt;
  endtask

  initial begin
    #(20 * 150_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low_ticks;
    logic [23:0] px;

    // Threshold vectors: 27-cycle highs decode as 0, 28 as 1, 4 (shortest legal) as 0.
    vecs[0] = '{24'hA5C3F0, 27, 38, 1'b1, 3'd0};
    vecs[1] = '{24'h5A3C0F, 4, 28, 1'b1, 3'd1};
    // Nine-pixel frame: only the first eight are addressable.
    for (int k = 0; k < 9; k++) begin
      vecs[2 + k].grb   = {8'(k * 17 + 1), 8'(8'hF0 - k), 8'(k + 8'h40)};
      vecs[2 + k].hi0   = 19;
      vecs[2 + k].hi1   = 38;
      vecs[2 + k].exp_v = (k < 8);
      vecs[2 + k].exp_a = 3'(k);
    end

    // Reset state
    reset = 1'b0;
    DI = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", {address, green, red, blue, pixel_valid, frame_done, error}, 32'd0);

    // SYNC -> READY without frame_done, then a single pixel and latch
    reset = 1'b1;
    snap();
    repeat (GAP) tick();
    chk("sync_no_frame_done", fd_cnt - fd0, 0);
    chk("sync_no_error", err_cnt - err0, 0);

    snap();
    push(3'd0, 24'h123456);
    send_px(24'h123456, 19, 38);
    low_ticks = 41;
    while (fd_cnt == fd0 && low_ticks < 3000) begin
      tick();
      low_ticks++;
    end
    chk("p1_frame_done_seen", fd_cnt - fd0, 1);
    // 2 synchronizer cycles + LATCH_CYC low cycles + 1 output register
    chk("p1_frame_done_latency", low_ticks, LATCH + 3);
    chk("p1_pixel_count", pv_cnt - pv0, 1);
    chk("p1_no_error", err_cnt - err0, 0);
    chk("p1_sb_empty", sb.size(), 0);
    repeat (30) tick();

    // Threshold edges
    snap();
    run_vec(0);
    run_vec(1);
    latch();
    chk("thr_pixels", pv_cnt - pv0, 2);
    chk("thr_frame_done", fd_cnt - fd0, 1);
    chk("thr_no_error", err_cnt - err0, 0);
    chk("thr_sb_empty", sb.size(), 0);

    // 3-cycle glitch -> error and SYNC; pulses before a full latch gap are ignored
    snap();
    send_bit(3, 40);
    chk("glitch_error", err_cnt - err0, 1);
    for (int b = 0; b < 6; b++) send_bit(38, 22);
    latch();
    chk("glitch_no_pixel", pv_cnt - pv0, 0);
    chk("glitch_no_frame_done", fd_cnt - fd0, 0);
    chk("glitch_error_once", err_cnt - err0, 1);
    snap();
    push(3'd0, 24'hC0FFEE);
    send_px(24'hC0FFEE, 19, 38);
    latch();
    chk("glitch_recover_pixel", pv_cnt - pv0, 1);
    chk("glitch_recover_fd", fd_cnt - fd0, 1);

    // Overflow frame of nine pixels
    snap();
    for (int i = 2; i < 11; i++) run_vec(i);
    latch();
    chk("ovf_pixels", pv_cnt - pv0, 8);
    chk("ovf_error_once", err_cnt - err0, 1);
    chk("ovf_frame_done", fd_cnt - fd0, 1);
    chk("ovf_sb_empty", sb.size(), 0);
    snap();
    push(3'd0, 24'h0F1E2D);
    send_px(24'h0F1E2D, 19, 38);
    latch();
    chk("ovf_restart_pixel", pv_cnt - pv0, 1);
    chk("ovf_restart_sb", sb.size(), 0);

    // Truncated pixel at latch
    snap();
    for (int b = 0; b < 12; b++) send_bit((b % 2) ? 38 : 19, (b % 2) ? 22 : 41);
    latch();
    chk("trunc_both", both_cnt - both0, 1);
    chk("trunc_error", err_cnt - err0, 1);
    chk("trunc_no_pixel", pv_cnt - pv0, 0);
    snap();
    push(3'd0, 24'h8001FE);
    send_px(24'h8001FE, 19, 38);
    latch();
    chk("trunc_next_pixel", pv_cnt - pv0, 1);
    chk("trunc_next_sb", sb.size(), 0);

    // Stuck high
    snap();
    DI = 1'b1;
    repeat (LATCH + 100) tick();
    chk("stuck_error", err_cnt - err0, 1);
    latch();
    chk("stuck_no_frame_done", fd_cnt - fd0, 0);
    chk("stuck_no_pixel", pv_cnt - pv0, 0);

    // Reset in the middle of a pixel
    push(3'd0, 24'h3C5A96);
    send_px(24'h3C5A96, 19, 38);
    for (int b = 0; b < 10; b++) send_bit(38, 22);
    DI = 1'b1;
    repeat (5) tick();
    snap();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("midreset_outputs", {address, green, red, blue, pixel_valid, frame_done, error}, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    latch();
    chk("midreset_no_strobes", (pv_cnt - pv0) + (fd_cnt - fd0) + (err_cnt - err0), 0);
    snap();
    push(3'd0, 24'h7E7E01);
    send_px(24'h7E7E01, 19, 38);
    latch();
    chk("midreset_next_pixel", pv_cnt - pv0, 1);

    // Loopback-style refresh of 8 triangle-wave colours
    snap();
    for (int i = 0; i < 8; i++) begin
      px = {8'(i * 32), 8'(255 - i * 32), 8'((i < 4) ? i * 64 : (7 - i) * 64)};
      push(3'(i), px);
      send_px(px, 19, 38);
    end
    latch();
    chk("loop_pixels", pv_cnt - pv0, 8);
    chk("loop_frame_done", fd_cnt - fd0, 1);
    chk("loop_no_error", err_cnt - err0, 0);
    chk("loop_sb_empty", sb.size(), 0);
    chk("never_pv_with_error", pe_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
